// File: rtl/i2s_sample_rx_pkg.sv
// Shared definitions for the I2S sample receiver: word size, channel encodings
// and the receive FSM state type.
package i2s_sample_rx_pkg;

    localparam int unsigned I2S_WORD_BITS = 16;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSkip  = 2'd1,
        StShift = 2'd2,
        StWait  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/bit_sync.sv
// Multi-stage flip-flop synchroniser bringing one asynchronous bit into the
// clock domain; resets to 0.
module bit_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_sample_rx.sv
// One-channel I2S deserialiser feeding the filter bank: captures 16-bit words and
// issues them as 1-clock strobes no closer than MIN_GAP clocks apart.
module i2s_sample_rx
    import i2s_sample_rx_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CHANNEL     = 0,
    parameter int unsigned MIN_GAP     = 64
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            sclk,
    input  logic                            lrck,
    input  logic                            sdata,
    input  logic                            ovr_clear,
    output logic signed [I2S_WORD_BITS-1:0] dataout,
    output logic                            dout_enable,
    output logic                            overrun,
    output logic                            short_frame
);

    localparam int unsigned GapW = $clog2(MIN_GAP + 1);
    localparam int unsigned CntW = $clog2(I2S_WORD_BITS);
    localparam logic CaptureLevel = (CHANNEL == 0) ? CH_LEFT : CH_RIGHT;

    logic sclk_s, lrck_s, sdata_s;
    logic sclk_prev_q, lrck_prev_q;
    logic sclk_rise, lrck_edge, enter_chan;

    rx_state_e state_q, state_d;
    logic      shift_en, word_done, short_evt;

    logic [CntW-1:0]            bit_cnt_q;
    logic                       last_bit;
    logic [I2S_WORD_BITS-2:0]   shift_q;
    logic [I2S_WORD_BITS-1:0]   word_in;
    logic [I2S_WORD_BITS-1:0]   hold_q;
    logic                       pending_q;
    logic [GapW-1:0]            gap_q;
    logic                       issue;

    bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clock (clock),
        .reset (reset),
        .din   (sclk),
        .dout  (sclk_s)
    );

    bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrck (
        .clock (clock),
        .reset (reset),
        .din   (lrck),
        .dout  (lrck_s)
    );

    bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdata (
        .clock (clock),
        .reset (reset),
        .din   (sdata),
        .dout  (sdata_s)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sclk_prev_q <= 1'b0;
            lrck_prev_q <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_s;
            lrck_prev_q <= lrck_s;
        end
    end

    assign sclk_rise  = sclk_s & ~sclk_prev_q;
    assign lrck_edge  = lrck_s ^ lrck_prev_q;
    assign enter_chan = lrck_edge && (lrck_s == CaptureLevel);
    assign last_bit   = (bit_cnt_q == CntW'(I2S_WORD_BITS - 1));

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // A word-select edge always restarts framing; the same edge may open a new word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (enter_chan) state_d = StSkip;
            end
            StSkip: begin
                if (lrck_edge)      state_d = enter_chan ? StSkip : StIdle;
                else if (sclk_rise) state_d = StShift;
            end
            StShift: begin
                if (lrck_edge)                  state_d = enter_chan ? StSkip : StIdle;
                else if (sclk_rise && last_bit) state_d = StWait;
            end
            StWait: begin
                if (lrck_edge) state_d = enter_chan ? StSkip : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        shift_en  = (state_q == StShift) && !lrck_edge && sclk_rise;
        word_done = shift_en && last_bit;
        short_evt = (state_q == StShift) && lrck_edge;
    end

    assign word_in = {shift_q, sdata_s};
    assign issue   = pending_q && (gap_q == GapW'(MIN_GAP));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            if (state_q != StShift) begin
                bit_cnt_q <= '0;
            end else if (shift_en) begin
                bit_cnt_q <= bit_cnt_q + CntW'(1);
            end
            if (shift_en) begin
                shift_q <= word_in[I2S_WORD_BITS-2:0];
            end
        end
    end

    // A word completing while an older one issues is not an overrun: both survive.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_q      <= '0;
            pending_q   <= 1'b0;
            gap_q       <= GapW'(MIN_GAP);
            dataout     <= '0;
            dout_enable <= 1'b0;
            overrun     <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            if (word_done) begin
                hold_q <= word_in;
            end
            if (word_done) begin
                pending_q <= 1'b1;
            end else if (issue) begin
                pending_q <= 1'b0;
            end
            if (issue) begin
                gap_q <= GapW'(1);
            end else if (gap_q != GapW'(MIN_GAP)) begin
                gap_q <= gap_q + GapW'(1);
            end
            if (issue) begin
                dataout <= hold_q;
            end
            dout_enable <= issue;
            if (word_done && pending_q && !issue) begin
                overrun <= 1'b1;
            end else if (ovr_clear) begin
                overrun <= 1'b0;
            end
            if (short_evt) begin
                short_frame <= 1'b1;
            end else if (ovr_clear) begin
                short_frame <= 1'b0;
            end
        end
    end

endmodule
